// File: rtl/cvxif_copro_responder.sv
// CV-X-IF coprocessor responder: decodes custom-3 ALU ops and accepts or rejects each issue.
// It holds accepted ops in order until they are committed or killed, then returns the result.
module cvxif_copro_responder #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned IdWidth    = 4,
    parameter int unsigned QueueDepth = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [31:0]        issue_instr_i,
    input  logic [IdWidth-1:0] issue_id_i,
    input  logic [XLEN-1:0]    issue_rs1_i,
    input  logic [XLEN-1:0]    issue_rs2_i,
    input  logic [1:0]         issue_rs_valid_i,
    output logic               issue_accept_o,
    output logic               issue_writeback_o,
    input  logic               commit_valid_i,
    input  logic [IdWidth-1:0] commit_id_i,
    input  logic               commit_kill_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [IdWidth-1:0] result_id_o,
    output logic [4:0]         result_rd_o,
    output logic               result_we_o,
    output logic [XLEN-1:0]    result_data_o
);

    localparam int unsigned CntW = $clog2(QueueDepth + 1);

    // Entries are kept compacted toward index 0, so index 0 is always the head.
    logic [QueueDepth-1:0] r_valid, r_cmt, r_we;
    logic [IdWidth-1:0]    r_id   [QueueDepth];
    logic [4:0]            r_rd   [QueueDepth];
    logic [XLEN-1:0]       r_data [QueueDepth];
    logic [CntW-1:0]       r_count;

    logic [QueueDepth-1:0] w_valid_d, w_cmt_d, w_we_d;
    logic [IdWidth-1:0]    w_id_d   [QueueDepth];
    logic [4:0]            w_rd_d   [QueueDepth];
    logic [XLEN-1:0]       w_data_d [QueueDepth];
    logic [CntW-1:0]       w_count_d;

    logic [2:0]      w_f3;
    logic            w_legal, w_need_rs1, w_need_rs2, w_we;
    logic [XLEN-1:0] w_data;
    logic            w_full, w_hs, w_push, w_pop;
    logic            w_unused_instr;

    assign w_f3           = issue_instr_i[14:12];
    assign w_unused_instr = ^issue_instr_i[24:15];

    always_comb begin
        w_legal    = 1'b0;
        w_need_rs1 = 1'b0;
        w_need_rs2 = 1'b0;
        w_we       = 1'b0;
        w_data     = '0;
        if (issue_instr_i[6:0] == 7'b1111011 && issue_instr_i[31:25] == 7'b0) begin
            case (w_f3)
                3'b000: begin
                    w_legal = 1'b1; w_need_rs1 = 1'b1; w_need_rs2 = 1'b1; w_we = 1'b1;
                    w_data  = issue_rs1_i + issue_rs2_i;
                end
                3'b001: begin
                    w_legal = 1'b1; w_need_rs1 = 1'b1; w_need_rs2 = 1'b1; w_we = 1'b1;
                    w_data  = issue_rs1_i ^ issue_rs2_i;
                end
                3'b010: begin
                    w_legal = 1'b1; w_need_rs1 = 1'b1; w_we = 1'b1;
                    w_data  = issue_rs1_i;
                end
                3'b011: begin
                    w_legal = 1'b1; w_need_rs1 = 1'b1; w_need_rs2 = 1'b1; w_we = 1'b1;
                    w_data  = issue_rs1_i - issue_rs2_i;
                end
                3'b100:  w_legal = 1'b1;
                default: w_legal = 1'b0;
            endcase
        end
    end

    assign w_full        = (r_count == CntW'(QueueDepth));
    assign issue_ready_o = !w_full && (!w_legal ||
                           ((!w_need_rs1 || issue_rs_valid_i[0]) &&
                            (!w_need_rs2 || issue_rs_valid_i[1])));
    assign w_hs              = issue_valid_i && issue_ready_o;
    assign w_push            = w_hs && w_legal;
    assign issue_accept_o    = w_push;
    assign issue_writeback_o = w_hs && w_we;

    assign result_valid_o = r_valid[0] && r_cmt[0];
    assign result_id_o    = r_id[0];
    assign result_rd_o    = r_rd[0];
    assign result_we_o    = r_we[0];
    assign result_data_o  = r_data[0];
    assign w_pop          = result_valid_o && result_ready_i;

    always_comb begin
        logic [QueueDepth-1:0] keep;
        logic [QueueDepth-1:0] cmt;
        logic                  matched;
        logic                  push_hit;
        int unsigned           wr;
        keep    = r_valid;
        cmt     = r_cmt;
        matched = 1'b0;
        for (int unsigned i = 0; i < QueueDepth; i++) begin
            if (commit_valid_i && !matched && r_valid[i] && !r_cmt[i] &&
                r_id[i] == commit_id_i) begin
                matched = 1'b1;
                if (commit_kill_i) keep[i] = 1'b0;
                else               cmt[i]  = 1'b1;
            end
        end
        if (w_pop) keep[0] = 1'b0;
        push_hit = commit_valid_i && !matched && w_push && (issue_id_i == commit_id_i);

        w_valid_d = '0;
        w_cmt_d   = '0;
        w_we_d    = '0;
        for (int unsigned i = 0; i < QueueDepth; i++) begin
            w_id_d[i]   = '0;
            w_rd_d[i]   = '0;
            w_data_d[i] = '0;
        end
        wr = 0;
        for (int unsigned i = 0; i < QueueDepth; i++) begin
            if (keep[i]) begin
                w_valid_d[wr] = 1'b1;
                w_cmt_d[wr]   = cmt[i];
                w_we_d[wr]    = r_we[i];
                w_id_d[wr]    = r_id[i];
                w_rd_d[wr]    = r_rd[i];
                w_data_d[wr]  = r_data[i];
                wr            = wr + 1;
            end
        end
        // A push only happens when not full, so wr is always in range here.
        if (w_push && !(push_hit && commit_kill_i) && wr < QueueDepth) begin
            w_valid_d[wr] = 1'b1;
            w_cmt_d[wr]   = push_hit;
            w_we_d[wr]    = w_we;
            w_id_d[wr]    = issue_id_i;
            w_rd_d[wr]    = issue_instr_i[11:7];
            w_data_d[wr]  = w_data;
            wr            = wr + 1;
        end
        w_count_d = CntW'(wr);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_cmt   <= '0;
            r_we    <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < QueueDepth; i++) begin
                r_id[i]   <= '0;
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_valid <= w_valid_d;
            r_cmt   <= w_cmt_d;
            r_we    <= w_we_d;
            r_count <= w_count_d;
            for (int unsigned i = 0; i < QueueDepth; i++) begin
                r_id[i]   <= w_id_d[i];
                r_rd[i]   <= w_rd_d[i];
                r_data[i] <= w_data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Directed bench for cvxif_copro_responder: inputs change on negedge, outputs checked 1ns later.
module tb_cvxif_copro_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [31:0] issue_instr_i;
    logic [3:0]  issue_id_i;
    logic [31:0] issue_rs1_i;
    logic [31:0] issue_rs2_i;
    logic [1:0]  issue_rs_valid_i;
    logic        issue_accept_o;
    logic        issue_writeback_o;
    logic        commit_valid_i;
    logic [3:0]  commit_id_i;
    logic        commit_kill_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [3:0]  result_id_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;
    logic [31:0] result_data_o;

    int n_checks = 0;
    int n_errors = 0;

    cvxif_copro_responder #(
        .XLEN       (32),
        .IdWidth    (4),
        .QueueDepth (2)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_o     (issue_ready_o),
        .issue_instr_i     (issue_instr_i),
        .issue_id_i        (issue_id_i),
        .issue_rs1_i       (issue_rs1_i),
        .issue_rs2_i       (issue_rs2_i),
        .issue_rs_valid_i  (issue_rs_valid_i),
        .issue_accept_o    (issue_accept_o),
        .issue_writeback_o (issue_writeback_o),
        .commit_valid_i    (commit_valid_i),
        .commit_id_i       (commit_id_i),
        .commit_kill_i     (commit_kill_i),
        .result_valid_o    (result_valid_o),
        .result_ready_i    (result_ready_i),
        .result_id_o       (result_id_o),
        .result_rd_o       (result_rd_o),
        .result_we_o       (result_we_o),
        .result_data_o     (result_data_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
        return {17'b0, f3, rd, 7'b1111011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic issue(input logic [2:0] f3, input logic [4:0] rd, input logic [3:0] id,
                         input logic [31:0] a, input logic [31:0] b, input logic [1:0] rv);
        issue_valid_i    = 1'b1;
        issue_instr_i    = mk(f3, rd);
        issue_id_i       = id;
        issue_rs1_i      = a;
        issue_rs2_i      = b;
        issue_rs_valid_i = rv;
    endtask

    task automatic commit(input logic [3:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
    endtask

    task automatic idle();
        issue_valid_i    = 1'b0;
        issue_instr_i    = 32'h0;
        issue_id_i       = 4'h0;
        issue_rs1_i      = 32'h0;
        issue_rs2_i      = 32'h0;
        issue_rs_valid_i = 2'b00;
        commit_valid_i   = 1'b0;
        commit_id_i      = 4'h0;
        commit_kill_i    = 1'b0;
    endtask

    initial begin
        rst_i          = 1'b1;
        result_ready_i = 1'b0;
        idle();
        #2;
        chk("rst_valid", 32'(result_valid_o), 32'h0);
        chk("rst_id",    32'(result_id_o),    32'h0);
        chk("rst_rd",    32'(result_rd_o),    32'h0);
        chk("rst_we",    32'(result_we_o),    32'h0);
        chk("rst_data",  result_data_o,       32'h0);
        step(); step();
        rst_i = 1'b0;
        #1 chk("ready_after_rst", 32'(issue_ready_o), 32'h1);

        // ADD 5 + 0xFFFFFFFE = 3
        step();
        result_ready_i = 1'b1;
        issue(3'b000, 5'd5, 4'd3, 32'h0000_0005, 32'hFFFF_FFFE, 2'b11);
        #1;
        chk("add_ready",  32'(issue_ready_o),     32'h1);
        chk("add_accept", 32'(issue_accept_o),    32'h1);
        chk("add_wb",     32'(issue_writeback_o), 32'h1);
        step(); idle(); commit(4'd3, 1'b0);
        #1 chk("add_not_yet", 32'(result_valid_o), 32'h0);
        step(); idle();
        #1;
        chk("add_valid", 32'(result_valid_o), 32'h1);
        chk("add_id",    32'(result_id_o),    32'd3);
        chk("add_rd",    32'(result_rd_o),    32'd5);
        chk("add_we",    32'(result_we_o),    32'h1);
        chk("add_data",  result_data_o,       32'h0000_0003);
        step();
        #1 chk("add_popped", 32'(result_valid_o), 32'h0);

        // Illegal funct3 with no operands: ready, rejected, commit ignored
        step();
        issue(3'b101, 5'd1, 4'd7, 32'h1, 32'h2, 2'b00);
        #1;
        chk("ill_ready",  32'(issue_ready_o),     32'h1);
        chk("ill_accept", 32'(issue_accept_o),    32'h0);
        chk("ill_wb",     32'(issue_writeback_o), 32'h0);
        step(); idle(); commit(4'd7, 1'b0);
        step(); idle();
        #1 chk("ill_no_result1", 32'(result_valid_o), 32'h0);
        step();
        #1 chk("ill_no_result2", 32'(result_valid_o), 32'h0);

        // SUB stalls on missing rs2 for 3 cycles: 0 - 1 = 0xFFFFFFFF
        for (int i = 0; i < 3; i++) begin
            step();
            issue(3'b011, 5'd2, 4'd4, 32'h0, 32'h1, 2'b01);
            #1;
            chk("sub_stall_ready",  32'(issue_ready_o),  32'h0);
            chk("sub_stall_accept", 32'(issue_accept_o), 32'h0);
        end
        step();
        issue_rs_valid_i = 2'b11;
        #1;
        chk("sub_ready",  32'(issue_ready_o),  32'h1);
        chk("sub_accept", 32'(issue_accept_o), 32'h1);
        step(); idle(); commit(4'd4, 1'b0);
        step(); idle();
        #1;
        chk("sub_valid", 32'(result_valid_o), 32'h1);
        chk("sub_id",    32'(result_id_o),    32'd4);
        chk("sub_rd",    32'(result_rd_o),    32'd2);
        chk("sub_data",  result_data_o,       32'hFFFF_FFFF);
        step();
        #1 chk("sub_popped", 32'(result_valid_o), 32'h0);

        // Fill with MOV id1 and NOP id2, kill id1, commit id2
        step();
        issue(3'b010, 5'd8, 4'd1, 32'h0000_AAAA, 32'h0, 2'b01);
        #1 chk("mov_accept", 32'(issue_accept_o), 32'h1);
        step();
        issue(3'b100, 5'd6, 4'd2, 32'h1234_5678, 32'h9, 2'b00);
        #1;
        chk("nop_accept", 32'(issue_accept_o),    32'h1);
        chk("nop_wb",     32'(issue_writeback_o), 32'h0);
        step();
        issue(3'b000, 5'd3, 4'd9, 32'h1, 32'h1, 2'b11);
        #1;
        chk("full_ready",  32'(issue_ready_o),  32'h0);
        chk("full_accept", 32'(issue_accept_o), 32'h0);
        step(); idle(); commit(4'd1, 1'b1);
        #1 chk("kill_no_result", 32'(result_valid_o), 32'h0);
        step(); idle(); commit(4'd2, 1'b0);
        #1;
        chk("after_kill_valid", 32'(result_valid_o), 32'h0);
        chk("after_kill_ready", 32'(issue_ready_o),  32'h1);
        step(); idle();
        #1;
        chk("nop_valid", 32'(result_valid_o), 32'h1);
        chk("nop_id",    32'(result_id_o),    32'd2);
        chk("nop_rd",    32'(result_rd_o),    32'd6);
        chk("nop_we",    32'(result_we_o),    32'h0);
        chk("nop_data",  result_data_o,       32'h0);
        step();
        #1;
        chk("nop_popped",  32'(result_valid_o), 32'h0);
        chk("ready_again", 32'(issue_ready_o),  32'h1);

        // Same-cycle issue+commit id5, backpressure for 4 cycles
        step();
        result_ready_i = 1'b0;
        issue(3'b001, 5'd9, 4'd5, 32'h0000_00F0, 32'h0000_00FF, 2'b11);
        commit(4'd5, 1'b0);
        #1 chk("xor_accept", 32'(issue_accept_o), 32'h1);
        step(); idle();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("hold_valid", 32'(result_valid_o), 32'h1);
            chk("hold_id",    32'(result_id_o),    32'd5);
            chk("hold_rd",    32'(result_rd_o),    32'd9);
            chk("hold_data",  result_data_o,       32'h0000_000F);
            step();
        end
        result_ready_i = 1'b1;
        #1 chk("pop5_valid", 32'(result_valid_o), 32'h1);
        step();
        #1 chk("pop5_done", 32'(result_valid_o), 32'h0);

        // Async reset with a committed entry waiting
        step();
        result_ready_i = 1'b0;
        issue(3'b000, 5'd4, 4'd6, 32'h10, 32'h20, 2'b11);
        commit(4'd6, 1'b0);
        step(); idle();
        #1 chk("pre_rst_valid", 32'(result_valid_o), 32'h1);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_valid", 32'(result_valid_o), 32'h0);
        chk("async_rst_data",  result_data_o,       32'h0);
        chk("async_rst_id",    32'(result_id_o),    32'h0);
        step();
        rst_i = 1'b0;
        #1 chk("post_rst_ready", 32'(issue_ready_o), 32'h1);
        // Count must be zero: exactly two pushes fit before full
        issue(3'b100, 5'd1, 4'd10, 32'h0, 32'h0, 2'b00);
        #1 chk("post_rst_push1", 32'(issue_accept_o), 32'h1);
        step();
        issue(3'b100, 5'd1, 4'd11, 32'h0, 32'h0, 2'b00);
        #1 chk("post_rst_push2", 32'(issue_accept_o), 32'h1);
        step();
        issue(3'b100, 5'd1, 4'd12, 32'h0, 32'h0, 2'b00);
        #1 chk("post_rst_full", 32'(issue_ready_o), 32'h0);
        step(); idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
